ats21_cmd_sched: RTL and testbench

Command scheduler in front of the ATS21 alarm/timer core. It accepts 32-bit instructions from client A and client B through independent valid/ready queues. It serializes them onto the ATS21 two-word control protocol (`req` plus upper half, then lower half), pairing A and B into a single transaction when both are pending. It waits for the core's `ready`, then returns the core's `stat`/`data` to the clients.

---
 rtl/ats21_pkg.sv | 30 +++
 rtl/ats21_cmd_fifo.sv | 47 ++++
 rtl/ats21_cmd_sched.sv | 170 +++++++++++++++++
 tb/tb_ats21_cmd_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// Shared types and widths for the ATS21 command scheduler: opcodes, FSM states, word sizes.
package ats21_pkg;

  localparam int HALF_W = 16;
  localparam int CMD_W  = 32;
  localparam int DATA_W = 24;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_SET_CLK   = 3'b001,
    OP_EN_CLK    = 3'b010,
    OP_MODE      = 3'b011,
    OP_ALARM     = 3'b101,
    OP_COUNTDOWN = 3'b110,
    OP_EN_AT     = 3'b111
  } ats_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WORD1,
    ST_WORD2,
    ST_WAIT
  } sched_state_e;

  // An unselected client contributes an all-zero (Nop) half-word.
  function automatic logic [HALF_W-1:0] mask_half(input logic en, input logic [HALF_W-1:0] w);
    return en ? w : '0;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Per-client synchronous command FIFO; head is the oldest entry, push is ignored when full.
module ats21_cmd_fifo
  import ats21_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ats21_cmd_sched.sv
// Serializes client A/B commands onto the ATS21 two-word req/ctrl protocol and returns stat/data.
// Optional WAIT abort counter enabled by defining ATS_SCHED_TIMEOUT_EN.
module ats21_cmd_sched
  import ats21_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [CMD_W-1:0]  a_cmd,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [CMD_W-1:0]  b_cmd,
  output logic              b_ready,
  output logic              ats_req,
  output logic [HALF_W-1:0] ats_ctrlA,
  output logic [HALF_W-1:0] ats_ctrlB,
  input  logic              ats_ready,
  input  logic [1:0]        ats_stat,
  input  logic [DATA_W-1:0] ats_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_client,
  output logic [1:0]        rsp_stat,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              rsp_timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("ats21_cmd_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  sched_state_e      state_q;
  logic [1:0]        sel_q;
  logic [1:0]        pend_q;
  logic              req_q;
  logic [HALF_W-1:0] ctrla_q, ctrlb_q;
  logic              rsp_valid_q;
  logic [1:0]        rsp_client_q, rsp_stat_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [CMD_W-1:0]  a_head, b_head;
  logic              a_full, a_empty, b_full, b_empty;
  logic              a_pop, b_pop;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_pop   = (state_q == ST_WORD2) && sel_q[0];
  assign b_pop   = (state_q == ST_WORD2) && sel_q[1];

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .reset (reset),
    .push  (a_valid),
    .pop   (a_pop),
    .din   (a_cmd),
    .head  (a_head),
    .full  (a_full),
    .empty (a_empty)
  );

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .reset (reset),
    .push  (b_valid),
    .pop   (b_pop),
    .din   (b_cmd),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

`ifdef ATS_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt_q;
  logic            rsp_to_q;
  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign ats_req    = req_q;
  assign ats_ctrlA  = ctrla_q;
  assign ats_ctrlB  = ctrlb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_client = rsp_client_q;
  assign rsp_stat   = rsp_stat_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != ST_IDLE);

  // pend_q is a registered look at the queues; it sets the accept-to-WORD1 latency
  // and is also the snapshot latched into sel_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      pend_q       <= '0;
      req_q        <= 1'b0;
      ctrla_q      <= '0;
      ctrlb_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_client_q <= '0;
      rsp_stat_q   <= '0;
      rsp_data_q   <= '0;
`ifdef ATS_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_to_q     <= 1'b0;
`endif
    end else begin
      pend_q      <= {!b_empty, !a_empty};
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          req_q   <= 1'b0;
          ctrla_q <= '0;
          ctrlb_q <= '0;
          if (|pend_q) begin
            sel_q   <= pend_q;
            req_q   <= 1'b1;
            ctrla_q <= mask_half(pend_q[0], a_head[CMD_W-1:HALF_W]);
            ctrlb_q <= mask_half(pend_q[1], b_head[CMD_W-1:HALF_W]);
            state_q <= ST_WORD1;
          end
        end
        ST_WORD1: begin
          req_q   <= 1'b0;
          ctrla_q <= mask_half(sel_q[0], a_head[HALF_W-1:0]);
          ctrlb_q <= mask_half(sel_q[1], b_head[HALF_W-1:0]);
          state_q <= ST_WORD2;
        end
        ST_WORD2: begin
          ctrla_q <= '0;
          ctrlb_q <= '0;
`ifdef ATS_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ats_ready) begin
            rsp_valid_q  <= 1'b1;
            rsp_client_q <= sel_q;
            rsp_stat_q   <= ats_stat;
            rsp_data_q   <= ats_data;
`ifdef ATS_SCHED_TIMEOUT_EN
            rsp_to_q     <= 1'b0;
`endif
            state_q      <= ST_IDLE;
          end
`ifdef ATS_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_client_q <= sel_q;
            rsp_stat_q   <= 2'b11;
            rsp_data_q   <= '0;
            rsp_to_q     <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_cmd_sched.sv
// Self-checking bench: queue/phase-offset reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_ats21_cmd_sched;

  localparam int DEPTH = 4;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_cmd = '0, b_cmd = '0;
  logic        a_ready, b_ready;
  logic        ats_req;
  logic [15:0] ats_ctrlA, ats_ctrlB;
  logic        ats_ready = 1'b1;
  logic [1:0]  ats_stat = '0;
  logic [23:0] ats_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_client, rsp_stat;
  logic [23:0] rsp_data;
  logic        busy, rsp_timeout;

  always #5 clk = ~clk;

  ats21_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
    .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
    .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
    .rsp_valid(rsp_valid), .rsp_client(rsp_client), .rsp_stat(rsp_stat),
    .rsp_data(rsp_data), .busy(busy), .rsp_timeout(rsp_timeout)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: client queues plus one in-flight transaction described by
  // its start edge (m_t0); outputs follow from the offset since that edge.
  logic [31:0] qa[$], qb[$];
  bit          m_busy = 0, m_prevA = 0, m_prevB = 0, m_rv = 0, m_to = 0;
  logic [1:0]  m_sel = '0, m_client = '0, m_stat = '0;
  logic [23:0] m_data = '0;
  logic [31:0] m_ca = '0, m_cb = '0;
  int          m_t0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    int ph;
    bit pa, pb, pusha, pushb;
    ph = cyc - m_t0;
    cyc = cyc + 1;
    if (reset) begin
      qa.delete(); qb.delete();
      m_busy = 0; m_prevA = 0; m_prevB = 0; m_rv = 0; m_to = 0;
      m_client = '0; m_stat = '0; m_data = '0; m_sel = '0;
    end else begin
      pusha = a_valid && (qa.size() < DEPTH);
      pushb = b_valid && (qb.size() < DEPTH);
      pa = m_prevA;
      pb = m_prevB;
      m_prevA = (qa.size() != 0);
      m_prevB = (qb.size() != 0);
      m_rv = 0;
      if (m_busy) begin
        if (ph == 1) begin
          if (m_sel[0]) void'(qa.pop_front());
          if (m_sel[1]) void'(qb.pop_front());
        end else if (ph >= 2) begin
          if (ats_ready) begin
            m_rv = 1; m_busy = 0; m_client = m_sel;
            m_stat = ats_stat; m_data = ats_data; m_to = 0;
          end
`ifdef ATS_SCHED_TIMEOUT_EN
          else if (ph - 2 == TO - 1) begin
            m_rv = 1; m_busy = 0; m_client = m_sel;
            m_stat = 2'b11; m_data = '0; m_to = 1;
          end
`endif
        end
      end else if (pa || pb) begin
        m_busy = 1;
        m_t0 = cyc;
        m_sel = {pb, pa};
        m_ca = pa ? qa[0] : 32'h0;
        m_cb = pb ? qb[0] : 32'h0;
      end
      if (pusha) qa.push_back(a_cmd);
      if (pushb) qb.push_back(b_cmd);
    end
  end

  always @(negedge clk) begin
    int ph;
    logic [15:0] ea, eb;
    bit ereq;
    if (chk_en) begin
      ph = cyc - m_t0;
      ereq = m_busy && (ph == 0);
      ea = '0;
      eb = '0;
      if (m_busy && ph == 0) begin
        ea = m_sel[0] ? m_ca[31:16] : 16'h0;
        eb = m_sel[1] ? m_cb[31:16] : 16'h0;
      end else if (m_busy && ph == 1) begin
        ea = m_sel[0] ? m_ca[15:0] : 16'h0;
        eb = m_sel[1] ? m_cb[15:0] : 16'h0;
      end
      chk("ats_req",     32'(ats_req),     32'(ereq));
      chk("ats_ctrlA",   32'(ats_ctrlA),   32'(ea));
      chk("ats_ctrlB",   32'(ats_ctrlB),   32'(eb));
      chk("busy",        32'(busy),        32'(m_busy));
      chk("a_ready",     32'(a_ready),     32'(qa.size() < DEPTH));
      chk("b_ready",     32'(b_ready),     32'(qb.size() < DEPTH));
      chk("rsp_valid",   32'(rsp_valid),   32'(m_rv));
      chk("rsp_client",  32'(rsp_client),  32'(m_client));
      chk("rsp_stat",    32'(rsp_stat),    32'(m_stat));
      chk("rsp_data",    32'(rsp_data),    32'(m_data));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
    end
  end

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((m_busy || qa.size() != 0 || qb.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n < 3000), 32'h1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt, last, gap_ok, tmo_at;

    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_req",   32'(ats_req),   32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_rsp",   32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'h1);
    chk("rst_b_ready", 32'(b_ready), 32'h1);
    repeat (2) @(negedge clk);

    // Single A command, ats_ready held high.
    ats_ready = 1; ats_stat = 2'b01; ats_data = 24'h123456;
    a_valid = 1; a_cmd = 32'h2600_0000;
    @(negedge clk);
    a_valid = 0; n0 = cyc;
    repeat (2) @(negedge clk);
    chk("t1_w1_req",   32'(ats_req),   32'h1);
    chk("t1_w1_ctrlA", 32'(ats_ctrlA), 32'h2600);
    chk("t1_w1_ctrlB", 32'(ats_ctrlB), 32'h0);
    @(negedge clk);
    chk("t1_w2_req",   32'(ats_req),   32'h0);
    chk("t1_w2_ctrlA", 32'(ats_ctrlA), 32'h0);
    @(negedge clk);
    chk("t1_wait_norsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("t1_lat", 32'(cyc - n0), 32'd5);
    chk("t1_rsp_valid",  32'(rsp_valid),  32'h1);
    chk("t1_rsp_client", 32'(rsp_client), 32'h1);
    chk("t1_rsp_data",   32'(rsp_data),   32'h123456);
    wait_quiet();

    // A and B pushed together pair into one transaction.
    a_valid = 1; a_cmd = 32'hA080_0090;
    b_valid = 1; b_cmd = 32'hB700_0090;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    repeat (2) @(negedge clk);
    chk("t2_w1_ctrlA", 32'(ats_ctrlA), 32'hA080);
    chk("t2_w1_ctrlB", 32'(ats_ctrlB), 32'hB700);
    @(negedge clk);
    chk("t2_w2_ctrlA", 32'(ats_ctrlA), 32'h0090);
    chk("t2_w2_ctrlB", 32'(ats_ctrlB), 32'h0090);
    repeat (2) @(negedge clk);
    chk("t2_rsp_client", 32'(rsp_client), 32'h3);
    wait_quiet();

    // Fill A while the core stalls, then release and check ordering/spacing.
    ats_ready = 0;
    a_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a_cmd = 32'h1111_0000 + 32'(i);
      @(negedge clk);
    end
    a_valid = 0;
    chk("t3_full", 32'(a_ready), 32'h0);
    @(negedge clk);
    chk("t3_slot_freed", 32'(a_ready), 32'h1);
    repeat (3) @(negedge clk);
    ats_ready = 1;
    cnt = 0; last = -100; gap_ok = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ats_data = 24'(i);
      if (rsp_valid) begin
        if (cyc - last < 4) gap_ok = 0;
        last = cyc;
        cnt++;
      end
    end
    chk("t3_rsp_count", 32'(cnt), 32'd4);
    chk("t3_rsp_gap",   32'(gap_ok), 32'h1);
    wait_quiet();

    // Core stalls 10 WAIT cycles, then returns a specific status.
    ats_ready = 0;
    a_valid = 1; a_cmd = 32'h5A00_0001;
    @(negedge clk);
    a_valid = 0; n0 = cyc;
    while (cyc < n0 + 4) @(negedge clk);
    repeat (10) @(negedge clk);
    ats_ready = 1; ats_stat = 2'b10; ats_data = 24'h00ABCD;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cnt++;
        chk("t4_rsp_stat", 32'(rsp_stat), 32'h2);
        chk("t4_rsp_data", 32'(rsp_data), 32'h00ABCD);
        chk("t4_rsp_lat",  32'(cyc - n0), 32'd15);
      end
    end
    chk("t4_rsp_count", 32'(cnt), 32'd1);
    wait_quiet();

    // Reset asserted while in WORD2 with two more commands queued.
    ats_ready = 1;
    a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      a_cmd = 32'h7000_0000 + 32'(i);
      @(negedge clk);
    end
    a_valid = 0;
    @(negedge clk);
    chk("t5_in_word2", 32'(busy), 32'h1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t5_req",     32'(ats_req),   32'h0);
    chk("t5_busy",    32'(busy),      32'h0);
    chk("t5_a_ready", 32'(a_ready),   32'h1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("t5_no_rsp",   32'(cnt),  32'd0);
    chk("t5_idle_after", 32'(busy), 32'h0);
    wait_quiet();

`ifdef ATS_SCHED_TIMEOUT_EN
    ats_ready = 0;
    a_valid = 1; a_cmd = 32'h6000_0042;
    @(negedge clk);
    a_valid = 0; n0 = cyc;
    tmo_at = -1;
    for (int i = 0; i < 120 && tmo_at < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        tmo_at = cyc;
        chk("t6_timeout", 32'(rsp_timeout), 32'h1);
        chk("t6_stat",    32'(rsp_stat),    32'h3);
      end
    end
    chk("t6_when", 32'(tmo_at - (n0 + 4)), 32'd64);
    @(negedge clk);
    chk("t6_idle", 32'(busy), 32'h0);
    ats_ready = 1;
    wait_quiet();
`else
    tmo_at = 0;
`endif

    // Randomized traffic, occasional resets; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      a_valid   = ($urandom_range(0, 2) == 0);
      a_cmd     = $urandom();
      b_valid   = ($urandom_range(0, 2) == 0);
      b_cmd     = $urandom();
      ats_ready = ($urandom_range(0, 3) != 0);
      ats_stat  = 2'($urandom());
      ats_data  = 24'($urandom());
      reset     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0; reset = 0; ats_ready = 1;
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
